// File: rtl/fp_result_collector_if.sv
// Bundle between the FP adder result stream, the operand source credit
// path and the downstream consumer of fp_result_collector.
// slave  : the collector side.
// master : the environment side (operand source, IP result, consumer).
interface fp_result_collector_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              issue_valid;
  logic              issue_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  inflight;
  logic              err;
  logic              flag_clr;
  logic              flag_nan;
  logic              flag_inf;

  modport slave (
    input  issue_valid, res_valid, res_data, out_ready, flag_clr,
    output issue_ready, out_valid, out_data, count, inflight, err, flag_nan, flag_inf
  );

  modport master (
    output issue_valid, res_valid, res_data, out_ready, flag_clr,
    input  issue_ready, out_valid, out_data, count, inflight, err, flag_nan, flag_inf
  );
endinterface

// File: rtl/fp_result_collector.sv
// fp_result_collector: credit-gated capture of the FP adder result stream
// (valid only, no backpressure) into a FWFT FIFO, re-presented downstream
// with valid/ready. Credits = DEPTH - (count + inflight), so every issued
// op is guaranteed a slot when its result arrives.
// Optional NaN/Inf sticky flags are built only with FP_RESULT_FLAG_EN defined.
module fp_result_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input logic                clock,
  input logic                reset,
  fp_result_collector_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, inflight_q;
  logic              err_q;
  logic [CNT_W:0]    credit_sum;
  logic              full, pop, push_ok, issue_fire, orphan, overflow;

  // Sum can exceed DEPTH only after protocol violations; one extra bit keeps it exact.
  assign credit_sum      = {1'b0, count_q} + {1'b0, inflight_q};
  assign bus.issue_ready = credit_sum < (CNT_W+1)'(DEPTH);
  assign full            = (count_q == CNT_W'(DEPTH));
  assign bus.out_valid   = (count_q != '0);
  assign pop             = bus.out_valid & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok         = bus.res_valid & (~full | pop);
  assign overflow        = bus.res_valid & full & ~pop;
  assign issue_fire      = bus.issue_valid & bus.issue_ready;
  assign orphan          = bus.res_valid & (inflight_q == '0);

  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.count    = count_q;
  assign bus.inflight = inflight_q;
  assign bus.err      = err_q;

  // Storage array: written on accepted results, no reset needed (read is gated by count).
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= bus.res_data;
  end

  // Pointers and occupancy; pointers wrap modulo DEPTH by width.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // In-flight tracking; an unmatched result never drives it below zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
    end else if (issue_fire & ~bus.res_valid) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (bus.res_valid & ~issue_fire & ~orphan) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  // Sticky protocol error: issue without credit, unmatched result, or dropped result.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((bus.issue_valid & ~bus.issue_ready) | orphan | overflow) begin
      err_q <= 1'b1;
    end
  end

`ifdef FP_RESULT_FLAG_EN
  logic nan_q, inf_q, exp_ones, mant_zero;

  assign exp_ones     = &bus.res_data[30:23];
  assign mant_zero    = (bus.res_data[22:0] == 23'd0);
  assign bus.flag_nan = nan_q;
  assign bus.flag_inf = inf_q;

  // Sticky IEEE-single NaN/Inf detect on accepted results; a new hit beats flag_clr.
  always_ff @(posedge clock) begin
    if (reset) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      if (push_ok & exp_ones & ~mant_zero) nan_q <= 1'b1;
      else if (bus.flag_clr)               nan_q <= 1'b0;
      if (push_ok & exp_ones & mant_zero)  inf_q <= 1'b1;
      else if (bus.flag_clr)               inf_q <= 1'b0;
    end
  end
`else
  logic unused_flag_clr;

  assign unused_flag_clr = bus.flag_clr;
  assign bus.flag_nan    = 1'b0;
  assign bus.flag_inf    = 1'b0;
`endif
endmodule

// File: tb/tb_fp_result_collector.sv
// Bench for fp_result_collector: queue scoreboard on the output stream,
// table-driven NaN/Inf flag vectors, hand sequences for credit/full/reset.
module tb_fp_result_collector;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
`ifdef FP_RESULT_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        clr;
    logic        nan;
    logic        inf;
  } flag_vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fp_result_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  fp_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Output monitor: a pop happens at the next posedge, compare head now.
  always @(negedge clock) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected got=%h want=none", bus.out_data);
      end else begin
        check("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_data    = '0;
    bus.flag_clr    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic issue(input int n);
    for (int i = 0; i < n; i++) begin
      bus.issue_valid = 1'b1;
      cyc();
    end
    bus.issue_valid = 1'b0;
  endtask

  task automatic deliver(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = base + 32'(i);
      exp_q.push_back(base + 32'(i));
      cyc();
    end
    bus.res_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
    check(name, 32'(exp_q.size()), 32'd0);
    sample();
    check({name, "_count"}, 32'(bus.count), 32'd0);
    check({name, "_ovalid"}, 32'(bus.out_valid), 32'd0);
    cyc();
  endtask

  initial begin
    flag_vec_t   fv [7];
    logic [31:0] t2 [3];
    int          issued;

    fv[0] = '{32'h3F800000, 1'b0, 1'b0, 1'b0};
    fv[1] = '{32'h7FC00000, 1'b0, 1'b1, 1'b0};
    fv[2] = '{32'h7F800000, 1'b0, 1'b1, 1'b1};
    fv[3] = '{32'h00000000, 1'b1, 1'b0, 1'b0};
    fv[4] = '{32'hFF800000, 1'b0, 1'b0, 1'b1};
    fv[5] = '{32'h7F800001, 1'b1, 1'b1, 1'b0};
    fv[6] = '{32'h7F7FFFFF, 1'b1, 1'b0, 1'b0};
    t2[0] = 32'h3F800000;
    t2[1] = 32'h40000000;
    t2[2] = 32'h40400000;

    // 1: reset state
    do_reset();
    sample();
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_inflight", 32'(bus.inflight), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_flags", {30'd0, bus.flag_nan, bus.flag_inf}, 32'd0);
    cyc();

    // 2: three ops, results ten cycles later, in order
    bus.out_ready = 1'b1;
    issue(3);
    sample();
    check("t2_inflight3", 32'(bus.inflight), 32'd3);
    cyc();
    repeat (10) cyc();
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = t2[i];
      exp_q.push_back(t2[i]);
      cyc();
    end
    bus.res_valid = 1'b0;
    drain("t2_drain");
    check("t2_inflight0", 32'(bus.inflight), 32'd0);
    check("t2_err", 32'(bus.err), 32'd0);

    // 3: credit limit with stalled consumer
    do_reset();
    issued = 0;
    for (int i = 0; i < 20; i++) begin
      check("t3_issue_ready", 32'(bus.issue_ready), 32'(issued < DEPTH));
      bus.issue_valid = (issued < DEPTH);
      if (issued < DEPTH) issued++;
      cyc();
    end
    bus.issue_valid = 1'b0;
    sample();
    check("t3_inflight16", 32'(bus.inflight), 32'd16);
    check("t3_ready0", 32'(bus.issue_ready), 32'd0);
    cyc();
    deliver(16, 32'h100);
    sample();
    check("t3_count16", 32'(bus.count), 32'd16);
    check("t3_inflight0", 32'(bus.inflight), 32'd0);
    check("t3_err", 32'(bus.err), 32'd0);
    check("t3_head", bus.out_data, 32'h100);
    cyc();
    repeat (3) cyc();
    sample();
    check("t3_head_hold", bus.out_data, 32'h100);
    cyc();
    drain("t3_drain");
    check("t3_credit_back", 32'(bus.issue_ready), 32'd1);

    // 4a: full FIFO, push and pop same cycle -> both happen, count stays 16
    do_reset();
    issue(16);
    deliver(16, 32'h200);
    sample();
    check("t4_full_err0", 32'(bus.err), 32'd0);
    cyc();
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hABCD0001;
    bus.out_ready = 1'b1;
    exp_q.push_back(32'hABCD0001);
    cyc();
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b0;
    sample();
    check("t4_pp_count", 32'(bus.count), 32'd16);
    check("t4_pp_head", bus.out_data, 32'h201);
    // full+push+pop raises no overflow; err here comes only from the extra
    // result having no matching issue (inflight was 0)
    check("t4_pp_err_orphan", 32'(bus.err), 32'd1);
    cyc();
    drain("t4_pp_drain");

    // 4b: full FIFO, push without pop -> dropped, err
    do_reset();
    issue(16);
    deliver(16, 32'h300);
    sample();
    check("t4_ovf_err0", 32'(bus.err), 32'd0);
    cyc();
    bus.res_valid = 1'b1;
    bus.res_data  = 32'hDEADBEEF;
    cyc();
    bus.res_valid = 1'b0;
    sample();
    check("t4_ovf_count", 32'(bus.count), 32'd16);
    check("t4_ovf_err", 32'(bus.err), 32'd1);
    check("t4_ovf_head", bus.out_data, 32'h300);
    cyc();
    drain("t4_ovf_drain");

    // 5: unmatched result, then reset mid-stream
    do_reset();
    bus.res_valid = 1'b1;
    bus.res_data  = 32'h00000055;
    exp_q.push_back(32'h00000055);
    cyc();
    bus.res_valid = 1'b0;
    sample();
    check("t5_orphan_err", 32'(bus.err), 32'd1);
    check("t5_orphan_inflight", 32'(bus.inflight), 32'd0);
    check("t5_orphan_count", 32'(bus.count), 32'd1);
    cyc();
    drain("t5_orphan_drain");
    do_reset();
    issue(4);
    deliver(2, 32'h400);
    sample();
    check("t5_mid_count", 32'(bus.count), 32'd2);
    check("t5_mid_inflight", 32'(bus.inflight), 32'd2);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    sample();
    check("t5_rst_count", 32'(bus.count), 32'd0);
    check("t5_rst_inflight", 32'(bus.inflight), 32'd0);
    check("t5_rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_odata", bus.out_data, 32'd0);
    check("t5_rst_ready", 32'(bus.issue_ready), 32'd1);
    cyc();

    // 6: NaN/Inf sticky flags (always 0 when the feature is not built)
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = fv[i].data;
      bus.flag_clr  = fv[i].clr;
      exp_q.push_back(fv[i].data);
      cyc();
      idle();
      sample();
      check($sformatf("t6_nan_%0d", i), 32'(bus.flag_nan), 32'(FLAG_EN & fv[i].nan));
      check($sformatf("t6_inf_%0d", i), 32'(bus.flag_inf), 32'(FLAG_EN & fv[i].inf));
      cyc();
    end
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
